// File: rtl/pattern_loader.sv
// Frame sequencer between the color-pattern generator and the NeoPixel serializer.
// Build option: define PATTERN_LOADER_HOLD_EN to add the `hold` (frozen display) input.
module pattern_loader #(
    parameter int GAP_CYCLES = 50000,
    parameter int GAP_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
`ifdef PATTERN_LOADER_HOLD_EN
    input  logic             hold,
`endif
    input  logic [62:0][7:0] color_array,
    input  logic [62:0][2:0] pixel_array,
    input  logic [6:0]       max_num_loads,
    output logic             load_valid,
    input  logic             load_ready,
    output logic [2:0]       load_pixel,
    output logic [7:0]       load_color,
    output logic             send_it,
    input  logic             send_done,
    output logic             busy
);

    localparam int ENTRIES = 63;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, GAP} state_t;

    state_t           state;
    logic [5:0]       ptr;
    logic [5:0]       cnt;
    logic [5:0]       n;
    logic [GAP_W-1:0] gap;
`ifdef PATTERN_LOADER_HOLD_EN
    logic [5:0]       start_ptr;
`endif

    logic [5:0] n_next;
    logic [5:0] cnt_inc;
    logic [5:0] ptr_inc;
    logic       gap_last;
    logic       frame_go;

    // Requests larger than the table size saturate to one full pass of the table.
    function automatic logic [5:0] sat_loads(input logic [6:0] req);
        return (req > 7'(ENTRIES)) ? 6'(ENTRIES) : req[5:0];
    endfunction

    function automatic logic [5:0] wrap_inc(input logic [5:0] p);
        return (p == 6'(ENTRIES - 1)) ? 6'd0 : p + 6'd1;
    endfunction

    assign n_next   = sat_loads(max_num_loads);
    assign cnt_inc  = cnt + 6'd1;
    assign ptr_inc  = wrap_inc(ptr);
    assign gap_last = (gap == GAP_W'(GAP_CYCLES - 1));
    // A frame starts from IDLE or directly at the end of the blink gap.
    assign frame_go = enable && ((state == IDLE) || ((state == GAP) && gap_last));

    // Payload is a live view of the tables so a pattern switch shows up on the next load.
    assign load_pixel = load_valid ? pixel_array[ptr] : 3'd0;
    assign load_color = load_valid ? color_array[ptr] : 8'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            n          <= '0;
            gap        <= '0;
            load_valid <= 1'b0;
            send_it    <= 1'b0;
            busy       <= 1'b0;
`ifdef PATTERN_LOADER_HOLD_EN
            start_ptr  <= '0;
`endif
        end else begin
            send_it <= 1'b0;
            unique case (state)
                IDLE: ;
                LOAD: begin
                    if (load_ready) begin
                        cnt <= cnt_inc;
                        ptr <= ptr_inc;
                        if (cnt_inc == n) begin
                            state      <= SEND;
                            load_valid <= 1'b0;
                            send_it    <= 1'b1;
                        end
                    end
                end
                SEND: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (send_done) begin
                        state <= GAP;
                        gap   <= '0;
                    end
                end
                GAP: begin
                    gap <= gap + GAP_W'(1);
                    if (gap_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame start overrides the IDLE/GAP exit above.
            if (frame_go) begin
                n    <= n_next;
                cnt  <= '0;
                busy <= 1'b1;
                if (n_next != 6'd0) begin
                    state      <= LOAD;
                    load_valid <= 1'b1;
                end else begin
                    state   <= SEND;
                    send_it <= 1'b1;
                end
`ifdef PATTERN_LOADER_HOLD_EN
                if (hold) ptr <= start_ptr;
                else      start_ptr <= ptr;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboard bench for pattern_loader: expected payloads are queued per frame and
// popped on every observed load transfer.
module tb_pattern_loader;

    localparam int GAP = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             hold = 1'b0;
    logic             load_ready = 1'b1;
    logic             send_done = 1'b0;
    logic [6:0]       max_num_loads = '0;
    logic [62:0][7:0] color_array;
    logic [62:0][2:0] pixel_array;
    logic             load_valid;
    logic [2:0]       load_pixel;
    logic [7:0]       load_color;
    logic             send_it;
    logic             busy;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int send_cnt = 0;
    int send_cyc = 0;
    int frame_xfers = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int tb_ptr = 0;
    int start_ptr = 0;
    int en_cyc = 0;
    bit rand_ready = 1'b0;
    bit stall_pend = 1'b0;
    bit prev_send = 1'b0;
    logic [10:0] stall_val;
    logic [10:0] exp_q[$];

    pattern_loader #(.GAP_CYCLES(GAP), .GAP_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
`ifdef PATTERN_LOADER_HOLD_EN
        .hold          (hold),
`endif
        .color_array   (color_array),
        .pixel_array   (pixel_array),
        .max_num_loads (max_num_loads),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_pixel    (load_pixel),
        .load_color    (load_color),
        .send_it       (send_it),
        .send_done     (send_done),
        .busy          (busy)
    );

    initial forever #5 clock = ~clock;
    initial forever begin @(posedge clock); cyc++; end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    // Serializer model: send_done is sampled 4 edges after the edge that raised send_it.
    initial forever begin
        @(negedge clock);
        if (send_it) begin
            repeat (3) @(posedge clock);
            #2 send_done = 1'b1;
            @(posedge clock);
            #2 send_done = 1'b0;
        end
    end

    initial forever begin
        @(posedge clock);
        #2 load_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            stall_pend = 1'b0;
            prev_send  = 1'b0;
        end else begin
            if (stall_pend) begin
                if (!load_valid) chk("valid_drop", load_valid, 1'b1);
                else chk("stall_hold", {load_pixel, load_color}, stall_val);
            end
            stall_pend = 1'b0;
            if (load_valid && load_ready) begin
                if (exp_q.size() == 0) chk("extra_load", load_valid, 1'b0);
                else chk("payload", {load_pixel, load_color}, exp_q.pop_front());
                frame_xfers++;
                if (frame_xfers == 1) first_cyc = cyc;
                last_cyc = cyc;
            end else if (load_valid) begin
                stall_pend = 1'b1;
                stall_val  = {load_pixel, load_color};
            end
            if (send_it) begin
                chk("send_pulse", prev_send, 1'b0);
                chk("send_after_loads", exp_q.size(), 0);
                if (frame_xfers > 0) chk("send_follows_last", cyc - last_cyc, 1);
                send_cnt++;
                send_cyc = cyc;
            end
            prev_send = send_it;
        end
    end

    task automatic push_frame(input int n);
        frame_xfers = 0;
        if (hold) tb_ptr = start_ptr;
        else start_ptr = tb_ptr;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({pixel_array[tb_ptr], color_array[tb_ptr]});
            tb_ptr = (tb_ptr == 62) ? 0 : tb_ptr + 1;
        end
    endtask

    task automatic wait_send(input int s0);
        int k = 0;
        while (send_cnt == s0 && k < 3000) begin
            @(posedge clock);
            k++;
        end
        chk("send_seen", send_cnt, s0 + 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            @(posedge clock);
            k++;
        end
        #1 chk("idle_busy", busy, 1'b0);
    endtask

    task automatic do_frames(input int mnl, input int frames, input bit rnd);
        int n;
        int s0;
        int prev;
        n = (mnl > 63) ? 63 : mnl;
        prev = 0;
        @(negedge clock);
        max_num_loads = 7'(mnl);
        rand_ready = rnd;
        for (int f = 0; f < frames; f++) begin
            push_frame(n);
            s0 = send_cnt;
            if (f == 0) begin
                enable = 1'b1;
                en_cyc = cyc;
            end
            wait_send(s0);
            chk("xfers", frame_xfers, n);
            if (!rnd) begin
                if (n > 0) chk("consec", last_cyc - first_cyc, n - 1);
                // First frame: loads in the n cycles after enable is sampled, then send.
                if (f == 0) chk("first_lat", send_cyc - en_cyc, n + 1);
                // Later frames: SEND, 3 WAIT_DONE cycles, GAP, then n loads.
                else chk("period", send_cyc - prev, n + 4 + GAP);
            end
            prev = send_cyc;
        end
        @(negedge clock);
        enable = 1'b0;
        rand_ready = 1'b0;
        wait_idle();
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        tb_ptr = 0;
        start_ptr = 0;
    endtask

    initial begin
        int s0;
        int k;
        #500000;
        $display("FAIL watchdog: sim time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        for (int i = 0; i < 63; i++) begin
            color_array[i] = 8'(i * 37 + 11);
            pixel_array[i] = 3'(i * 3 + 1);
        end
        repeat (3) @(negedge clock);
        chk("rst_state", {load_valid, load_pixel, load_color, send_it, busy}, 0);
        reset = 1'b1;

        do_frames(15, 2, 1'b0);

        // Reset in the middle of a LOAD phase abandons the frame.
        @(negedge clock);
        max_num_loads = 7'd10;
        push_frame(10);
        enable = 1'b1;
        k = 0;
        while (frame_xfers < 2 && k < 100) begin @(negedge clock); k++; end
        s0 = send_cnt;
        reset = 1'b0;
        enable = 1'b0;
        #1 chk("rst_outs", {load_valid, load_pixel, load_color, send_it, busy}, 0);
        @(negedge clock);
        chk("rst_outs_next", {load_valid, load_pixel, load_color, send_it, busy}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        tb_ptr = 0;
        start_ptr = 0;
        repeat (15) @(negedge clock);
        chk("no_send_rst", send_cnt, s0);

        do_frames(63, 2, 1'b0);
        do_frames(20, 2, 1'b1);
        do_frames(100, 1, 1'b0);
        do_frames(0, 1, 1'b0);

        // Dropping enable mid-frame lets the frame finish, then the block idles.
        @(negedge clock);
        max_num_loads = 7'd31;
        push_frame(31);
        s0 = send_cnt;
        enable = 1'b1;
        k = 0;
        while (frame_xfers < 3 && k < 100) begin @(negedge clock); k++; end
        enable = 1'b0;
        wait_send(s0);
        chk("drop_xfers", frame_xfers, 31);
        wait_idle();
        repeat (GAP + 6) @(negedge clock);
        chk("stay_idle", busy, 1'b0);
        chk("one_send", send_cnt, s0 + 1);

`ifdef PATTERN_LOADER_HOLD_EN
        pulse_reset();
        hold = 1'b1;
        do_frames(15, 3, 1'b0);
        hold = 1'b0;
        do_frames(15, 1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pattern_loader.md
# pattern_loader

Sequencer that sits directly downstream of the color-pattern generator and upstream of the NeoPixel serializer. Each frame, it walks the generator's 63-entry color/pixel tables and issues N pixel loads over a valid/ready handshake, where N is the generator's `max_num_loads`. It then commands the serializer to transmit, waits for completion, and idles for a programmable blink gap before the next frame. The entry pointer carries over across frames, so successive frames scroll through the pattern tables.

## Interface
Parameters:
- `GAP_CYCLES`, default 50000: idle cycles between `send_done` and the next frame's first load (1 ms at 50 MHz); must be ≥1.
- `GAP_W`, default 16: width of the gap counter; must hold `GAP_CYCLES`.

Ports:
- `clock`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run request, level-sensitive.
- `color_array`, in, [62:0][7:0]: intensity per entry.
- `pixel_array`, in, [62:0][2:0]: target pixel per entry.
- `max_num_loads`, in, 7: loads per frame.
- `load_valid`, out, 1: load payload valid.
- `load_ready`, in, 1: serializer accepts the load.
- `load_pixel`, out, 3: `pixel_array[ptr]`.
- `load_color`, out, 8: `color_array[ptr]`.
- `send_it`, out, 1: one-cycle transmit command.
- `send_done`, in, 1: serializer finished transmitting.
- `busy`, out, 1: high in any state other than IDLE.
- `hold`, in, 1: present only with `PATTERN_LOADER_HOLD_EN`.

## Operation
- States: IDLE, LOAD, SEND, WAIT_DONE, GAP.
- IDLE: when `enable`=1, latch `n = min(max_num_loads, 63)` and `cnt = 0`.
  - `n` > 0: go to LOAD.
  - `n` = 0: go to SEND.
- LOAD: `load_valid`=1, and the payload is read combinationally from the arrays at `ptr`.
  - A transfer occurs on `load_valid & load_ready`. Each transfer increments `cnt` and advances `ptr` (62→0 wrap, 6-bit).
  - Go to SEND on the transfer where `cnt` reaches `n`.
- SEND: `send_it`=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: stay until `send_done`=1, then go to GAP with `gap = 0`. `send_done` is ignored in every other state.
- GAP: increment `gap` each cycle. When `gap == GAP_CYCLES-1`:
  - `enable`=1: re-latch `n` from current `max_num_loads`, clear `cnt`, and go to LOAD (or SEND if `n` = 0).
  - `enable`=0: go to IDLE.
- `enable` dropping mid-frame does not abort the frame. The frame completes and the block returns to IDLE after GAP.
- `max_num_loads` is sampled only at frame start. Changes mid-frame take effect on the next frame.
- `color_array`/`pixel_array` are not registered. A pattern switch mid-frame changes the payload of subsequent loads. Payload must be stable only while the inputs are stable.
- `ptr` is not reset by IDLE. Only `reset` clears it.

## Timing
- Reset (`reset`=0, asynchronous) forces IDLE. All outputs reset to 0: `load_valid`, `load_pixel`, `load_color` (driven 0 outside LOAD), `send_it`, and `busy`. `ptr`, `cnt`, `n` and `gap` also reset to 0.
- Reset asserted mid-frame abandons the frame. No `send_it` is issued.
- IDLE→LOAD: `load_valid` rises 1 cycle after `enable` is sampled high.
- Handshake rules:
  - `load_valid` is never deasserted without a transfer.
  - While `load_valid` & !`load_ready`, `ptr` does not change.
  - With `load_ready` tied high, one load transfers per cycle.
- `send_it` is asserted in the cycle after the last transfer.
- Minimum frame period with `load_ready`=1 and `send_done` returned immediately: `n` + 2 + `GAP_CYCLES` cycles.
- `send_done` arriving in the same cycle as `send_it` is ignored. It must be asserted while in WAIT_DONE.

## Configuration
- `PATTERN_LOADER_HOLD_EN` defined: the `hold` port exists.
  - `hold`=1 sampled at frame start restores `ptr` to its value at the previous frame start, so the frame repeats the same entries (frozen display).
  - `hold` is sampled only at frame start.
- `PATTERN_LOADER_HOLD_EN` undefined: no `hold` port, and `ptr` always advances.

## Test plan
- Reset, then `enable`=1, `max_num_loads`=15, `load_ready`=1, `send_done` returned 3 cycles after `send_it`, `GAP_CYCLES`=4 → 15 loads of entries 0..14 on consecutive cycles. One `send_it` follows the last load. The next frame starts with entry 15.
- `max_num_loads`=63, run 2 frames → frame 2 starts at entry 0 (wrap). `load_pixel`/`load_color` match `pixel_array[k]`/`color_array[k]` for k = 0..62.
- Toggle `load_ready` randomly with 50% duty → payload is held stable while stalled. The correct values are seen in order, and exactly `n` transfers occur.
- `max_num_loads`=100 → clamped to 63 loads. `max_num_loads`=0 → no `load_valid`, and `send_it` is issued 1 cycle after frame start.
- Drop `enable` after the 3rd load of a 31-load frame → all 31 loads complete, then `send_it`, GAP, then IDLE with `busy`=0. Assert `reset` during LOAD → all outputs are 0 next cycle, and no `send_it` is issued.
- `PATTERN_LOADER_HOLD_EN` with `hold`=1 and `n`=15 → every frame loads entries 0..14. Releasing `hold` → the next frame loads entries 15..29.
